// File: rtl/qdma_stm_c2h_stub.sv
// rtl/qdma_stm_c2h_stub.sv - C2H stream stub: header strip, qid/mdata tagging, drop and stats
// Optional statistics (pkt_cnt, drop_cnt, err_sticky) built only with QDMA_C2H_STUB_STATS_EN.
module qdma_stm_c2h_stub #(
  parameter int MAX_DATA_WIDTH = 512,
  parameter int QID_BITS       = 11,
  parameter int CNT_BITS       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MAX_DATA_WIDTH-1:0] in_axis_tdata,
  input  logic                      in_axis_tuser,
  input  logic                      in_axis_tlast,
  input  logic                      in_axis_tvalid,
  output logic                      in_axis_tready,
  output logic [MAX_DATA_WIDTH-1:0] out_axis_tdata,
  output logic [QID_BITS-1:0]       out_axis_qid,
  output logic [31:0]               out_axis_mdata,
  output logic                      out_axis_tlast,
  output logic                      out_axis_tvalid,
  input  logic                      out_axis_tready,
  output logic [CNT_BITS-1:0]       pkt_cnt,
  output logic [CNT_BITS-1:0]       drop_cnt,
  output logic                      err_sticky
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PLD  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              state;
  logic [QID_BITS-1:0] qid_q;
  logic [31:0]         mdata_q;
  logic                in_accept;
  logic                pld_load;

  // Only the payload state is throttled by the single-entry output register.
  always_comb begin
    in_axis_tready = 1'b0;
    if (!rst) begin
      in_axis_tready = (state != S_PLD) || !out_axis_tvalid || out_axis_tready;
    end
  end

  assign in_accept = in_axis_tvalid && in_axis_tready;
  assign pld_load  = in_accept && (state == S_PLD) && !in_axis_tuser;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_HDR;
      qid_q   <= '0;
      mdata_q <= '0;
    end else if (in_accept) begin
      case (state)
        S_HDR: begin
          if (in_axis_tuser) begin
            if (!in_axis_tlast) begin
              qid_q   <= in_axis_tdata[QID_BITS-1:0];
              mdata_q <= in_axis_tdata[63:32];
              state   <= S_PLD;
            end
          end else if (!in_axis_tlast) begin
            state <= S_DROP;
          end
        end
        S_PLD: begin
          // A stray header inside a packet is discarded; the latched tag is kept.
          if (!in_axis_tuser && in_axis_tlast) begin
            state <= S_HDR;
          end
        end
        S_DROP: begin
          if (in_axis_tlast) begin
            state <= S_HDR;
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_axis_tvalid <= 1'b0;
      out_axis_tlast  <= 1'b0;
      out_axis_qid    <= '0;
      out_axis_mdata  <= '0;
      out_axis_tdata  <= '0;
    end else if (pld_load) begin
      out_axis_tvalid <= 1'b1;
      out_axis_tlast  <= in_axis_tlast;
      out_axis_qid    <= qid_q;
      out_axis_mdata  <= mdata_q;
      out_axis_tdata  <= in_axis_tdata;
    end else if (out_axis_tready) begin
      out_axis_tvalid <= 1'b0;
    end
  end

`ifdef QDMA_C2H_STUB_STATS_EN
  logic drop_inc;
  logic err_set;
  logic pkt_inc;

  always_comb begin
    drop_inc = 1'b0;
    err_set  = 1'b0;
    pkt_inc  = 1'b0;
    if (in_accept) begin
      case (state)
        S_HDR: begin
          if (!in_axis_tuser) begin
            drop_inc = 1'b1;
            err_set  = 1'b1;
          end else if (in_axis_tlast) begin
            drop_inc = 1'b1;
          end
        end
        S_PLD: begin
          if (in_axis_tuser) begin
            drop_inc = 1'b1;
            err_set  = 1'b1;
          end else if (in_axis_tlast) begin
            pkt_inc = 1'b1;
          end
        end
        S_DROP: drop_inc = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (pkt_inc) begin
        pkt_cnt <= pkt_cnt + CNT_BITS'(1);
      end
      if (drop_inc) begin
        drop_cnt <= drop_cnt + CNT_BITS'(1);
      end
      if (err_set) begin
        err_sticky <= 1'b1;
      end
    end
  end
`else
  assign pkt_cnt    = '0;
  assign drop_cnt   = '0;
  assign err_sticky = 1'b0;
`endif

endmodule
